uart_rx_frame_check: RTL and testbench

UART_RX_FRAME_CHECK -- requirements
Module: uart_rx_frame_check

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_frame_check_if.sv | 33 +++
 rtl/uart_parity_gen.sv | 27 ++
 rtl/uart_rx_frame_check.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_frame_check.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Purpose : shared UART receive definitions: parity-mode encoding and the
//           frame-checker FSM state encoding.
// Ports   : none (package).
package uart_rx_pkg;

  // Encoding of the Par_Mode input.
  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_e;

  // Frame-checker FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_frame_check_if.sv
// Purpose : bit-strobe input side and frame-result output side of the UART
//           receive frame checker.
// Ports   : master drives config/strobe/abort and observes results;
//           slave (the checker) observes config/strobe/abort and drives results.
interface uart_rx_frame_check_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  // Towards the checker
  logic          Par_En;
  logic [1:0]    Par_Mode;
  logic          Stop2;
  logic          Bit_Available;
  logic          Sampled_bit;
  logic          Frame_Abort;
  // From the checker
  logic [DW-1:0] P_Data;
  logic          Data_Valid;
  logic          Parity_Err;
  logic          Stop_Err;
  logic          Break_Det;
  logic [CW-1:0] Err_Cnt;

  modport master (
    output Par_En, Par_Mode, Stop2, Bit_Available, Sampled_bit, Frame_Abort,
    input  P_Data, Data_Valid, Parity_Err, Stop_Err, Break_Det, Err_Cnt
  );

  modport slave (
    input  Par_En, Par_Mode, Stop2, Bit_Available, Sampled_bit, Frame_Abort,
    output P_Data, Data_Valid, Parity_Err, Stop_Err, Break_Det, Err_Cnt
  );
endinterface

// File: rtl/uart_parity_gen.sv
// Purpose : expected parity bit for a DW-bit word under a given parity mode
//           (shared between receive checking and transmit generation).
// Latency : combinational.
// Backpressure: none.
// Ports   : data_i (DW) word, mode_i parity mode, par_o expected parity bit.
module uart_parity_gen
  import uart_rx_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] data_i,
  input  par_mode_e     mode_i,
  output logic          par_o
);

  always_comb begin
    par_o = 1'b0;
    case (mode_i)
      PAR_EVEN:  par_o = ^data_i;
      PAR_ODD:   par_o = ~^data_i;
      PAR_MARK:  par_o = 1'b1;
      PAR_SPACE: par_o = 1'b0;
      default:   par_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_rx_frame_check.sv
// Purpose : assembles sampled UART bits into a frame (start, DW data LSB first,
//           optional parity, 1 or 2 stops) and reports data plus frame errors.
// Latency : Data_Valid and results appear the cycle after the final stop strobe.
// Backpressure: none; every Bit_Available strobe is consumed, Frame_Abort drops
//           the partial frame.
// Ports   : CLK, RST (async active-low), bus (slave modport): config, bit strobe,
//           abort in; P_Data, Data_Valid, Parity_Err, Stop_Err, Break_Det,
//           Err_Cnt out (all registered).
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_rx_frame_check_if.slave  bus
);

  localparam int            BCW      = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DW - 1);

  // Frame-in-progress state
  rx_state_e      state_q,    state_d;
  logic [DW-1:0]  shreg_q,    shreg_d;
  logic [BCW-1:0] bitcnt_q,   bitcnt_d;
  logic           par_en_q,   par_en_d;
  par_mode_e      par_mode_q, par_mode_d;
  logic           stop2_q,    stop2_d;
  logic           perr_q,     perr_d;
  logic           serr_q,     serr_d;
  // Any 1 seen on data, parity or first stop; its absence is a break.
  logic           ones_q,     ones_d;
  logic           done_d;

  // Registered outputs
  logic [DW-1:0]  p_data_q;
  logic           dv_q;
  logic           parity_err_q;
  logic           stop_err_q;
  logic           break_q;
  logic [CW-1:0]  err_cnt_q;

  logic           exp_par;
  logic           bit_in;

  assign bit_in = bus.Sampled_bit;

  // Data is complete in shreg_q by the time the parity bit is sampled.
  uart_parity_gen #(.DW(DW)) u_par (
    .data_i (shreg_q),
    .mode_i (par_mode_q),
    .par_o  (exp_par)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      par_en_q   <= 1'b0;
      par_mode_q <= PAR_EVEN;
      stop2_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      ones_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      par_en_q   <= par_en_d;
      par_mode_q <= par_mode_d;
      stop2_q    <= stop2_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      ones_q     <= ones_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    par_en_d   = par_en_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    perr_d     = perr_q;
    serr_d     = serr_q;
    ones_d     = ones_q;
    done_d     = 1'b0;

    // Abort has priority; a coincident strobe is dropped.
    if (bus.Frame_Abort) begin
      state_d  = ST_IDLE;
      shreg_d  = '0;
      bitcnt_d = '0;
      perr_d   = 1'b0;
      serr_d   = 1'b0;
      ones_d   = 1'b0;
    end else if (bus.Bit_Available) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_in) begin
            // Frame format is frozen for the whole frame here.
            state_d    = ST_DATA;
            par_en_d   = bus.Par_En;
            par_mode_d = par_mode_e'(bus.Par_Mode);
            stop2_d    = bus.Stop2;
            shreg_d    = '0;
            bitcnt_d   = '0;
            perr_d     = 1'b0;
            serr_d     = 1'b0;
            ones_d     = 1'b0;
          end
        end
        ST_DATA: begin
          shreg_d = {bit_in, shreg_q[DW-1:1]};
          ones_d  = ones_q | bit_in;
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = '0;
            state_d  = par_en_q ? ST_PARITY : ST_STOP1;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_in != exp_par) perr_d = 1'b1;
          ones_d  = ones_q | bit_in;
          state_d = ST_STOP1;
        end
        ST_STOP1: begin
          if (!bit_in) serr_d = 1'b1;
          ones_d = ones_q | bit_in;
          if (stop2_q) begin
            state_d = ST_STOP2;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        ST_STOP2: begin
          // Second stop bit does not participate in break detection.
          if (!bit_in) serr_d = 1'b1;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Results are captured on the final stop strobe and held until the next one.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_data_q     <= '0;
      dv_q         <= 1'b0;
      parity_err_q <= 1'b0;
      stop_err_q   <= 1'b0;
      break_q      <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      dv_q <= done_d;
      if (done_d) begin
        p_data_q     <= shreg_q;
        parity_err_q <= perr_d;
        stop_err_q   <= serr_d;
        break_q      <= ~ones_d;
        if ((perr_d || serr_d) && (err_cnt_q != {CW{1'b1}})) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.P_Data     = p_data_q;
  assign bus.Data_Valid = dv_q;
  assign bus.Parity_Err = parity_err_q;
  assign bus.Stop_Err   = stop_err_q;
  assign bus.Break_Det  = break_q;
  assign bus.Err_Cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Purpose : directed self-checking bench for uart_rx_frame_check using three
//           instances: A (DW=8,CW=8), B (DW=7,CW=8), C (DW=8,CW=2).
// Ports   : none.
module tb_uart_rx_frame_check;

  logic       clk;
  logic       rst_n;
  logic       cfg_pe;
  logic [1:0] cfg_pm;
  logic       cfg_s2;
  logic       bav;
  logic       sbit;
  logic       abort;
  int         sel;

  int n_chk  = 0;
  int n_fail = 0;
  int dv_cnt_a = 0;
  int dv_cnt_b = 0;
  int dv_cnt_c = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frame_check_if #(.DW(8), .CW(8)) ifa ();
  uart_rx_frame_check_if #(.DW(7), .CW(8)) ifb ();
  uart_rx_frame_check_if #(.DW(8), .CW(2)) ifc ();

  assign ifa.Par_En = cfg_pe;  assign ifa.Par_Mode = cfg_pm;  assign ifa.Stop2 = cfg_s2;
  assign ifb.Par_En = cfg_pe;  assign ifb.Par_Mode = cfg_pm;  assign ifb.Stop2 = cfg_s2;
  assign ifc.Par_En = cfg_pe;  assign ifc.Par_Mode = cfg_pm;  assign ifc.Stop2 = cfg_s2;
  assign ifa.Sampled_bit = sbit;
  assign ifb.Sampled_bit = sbit;
  assign ifc.Sampled_bit = sbit;
  assign ifa.Bit_Available = bav && (sel == 0);
  assign ifb.Bit_Available = bav && (sel == 1);
  assign ifc.Bit_Available = bav && (sel == 2);
  assign ifa.Frame_Abort = abort && (sel == 0);
  assign ifb.Frame_Abort = abort && (sel == 1);
  assign ifc.Frame_Abort = abort && (sel == 2);

  uart_rx_frame_check #(.DW(8), .CW(8)) dut_a (.CLK(clk), .RST(rst_n), .bus(ifa));
  uart_rx_frame_check #(.DW(7), .CW(8)) dut_b (.CLK(clk), .RST(rst_n), .bus(ifb));
  uart_rx_frame_check #(.DW(8), .CW(2)) dut_c (.CLK(clk), .RST(rst_n), .bus(ifc));

  // Data_Valid pulses counted at the falling edge, where each pulse is seen once.
  always @(negedge clk) begin
    if (ifa.Data_Valid) dv_cnt_a++;
    if (ifb.Data_Valid) dv_cnt_b++;
    if (ifc.Data_Valid) dv_cnt_c++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Entered at a falling edge; returns at the next falling edge with the
  // strobe removed, i.e. in the cycle after the strobe was captured.
  task automatic strobe(input logic b);
    bav  = 1'b1;
    sbit = b;
    @(negedge clk);
    bav  = 1'b0;
    sbit = 1'b1;
  endtask

  task automatic send_frame(input int nb, input logic [8:0] d, input bit hp,
                            input logic pb, input logic s1, input bit h2, input logic s2b);
    strobe(1'b0);
    for (int i = 0; i < nb; i++) strobe(d[i]);
    if (hp) strobe(pb);
    strobe(s1);
    if (h2) strobe(s2b);
  endtask

  int cnt_snap;

  initial begin
    rst_n = 1'b0; cfg_pe = 1'b0; cfg_pm = 2'b00; cfg_s2 = 1'b0;
    bav = 1'b0; sbit = 1'b1; abort = 1'b0; sel = 0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_pdata",  32'(ifa.P_Data), 32'h0);
    check_eq("rst_dv",     32'(ifa.Data_Valid), 32'h0);
    check_eq("rst_perr",   32'(ifa.Parity_Err), 32'h0);
    check_eq("rst_serr",   32'(ifa.Stop_Err), 32'h0);
    check_eq("rst_brk",    32'(ifa.Break_Det), 32'h0);
    check_eq("rst_errcnt", 32'(ifa.Err_Cnt), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle line strobes (1) are ignored.
    strobe(1'b1); strobe(1'b1);

    // A: even, 1 stop, 0xA5 (four ones -> parity 0)
    sel = 0; cfg_pe = 1'b1; cfg_pm = 2'b00; cfg_s2 = 1'b0;
    send_frame(8, 9'h0A5, 1, 1'b0, 1'b1, 0, 1'b1);
    check_eq("a5_dv",     32'(ifa.Data_Valid), 32'h1);
    check_eq("a5_pdata",  32'(ifa.P_Data), 32'hA5);
    check_eq("a5_perr",   32'(ifa.Parity_Err), 32'h0);
    check_eq("a5_serr",   32'(ifa.Stop_Err), 32'h0);
    check_eq("a5_brk",    32'(ifa.Break_Det), 32'h0);
    check_eq("a5_errcnt", 32'(ifa.Err_Cnt), 32'h0);
    @(negedge clk);
    check_eq("a5_dv_one_cycle", 32'(ifa.Data_Valid), 32'h0);
    check_eq("a5_dv_count", 32'(dv_cnt_a), 32'd1);

    // A: odd, 0x0F, wrong parity 0, then back-to-back with correct parity 1
    cfg_pm = 2'b01;
    send_frame(8, 9'h00F, 1, 1'b0, 1'b1, 0, 1'b1);
    check_eq("odd_bad_perr",   32'(ifa.Parity_Err), 32'h1);
    check_eq("odd_bad_errcnt", 32'(ifa.Err_Cnt), 32'h1);
    send_frame(8, 9'h00F, 1, 1'b1, 1'b1, 0, 1'b1);
    check_eq("odd_ok_dv",     32'(ifa.Data_Valid), 32'h1);
    check_eq("odd_ok_perr",   32'(ifa.Parity_Err), 32'h0);
    check_eq("odd_ok_errcnt", 32'(ifa.Err_Cnt), 32'h1);
    @(negedge clk);
    check_eq("b2b_dv_count", 32'(dv_cnt_a), 32'd3);

    // A: config latched at start; Par_En dropped mid-frame must not take effect.
    // 0x01 even -> expected parity 1; parity sent 0 -> parity error only.
    cfg_pm = 2'b00;
    strobe(1'b0);
    cfg_pe = 1'b0;
    for (int i = 0; i < 8; i++) strobe(i == 0);
    strobe(1'b0);
    strobe(1'b1);
    check_eq("latch_dv",     32'(ifa.Data_Valid), 32'h1);
    check_eq("latch_perr",   32'(ifa.Parity_Err), 32'h1);
    check_eq("latch_serr",   32'(ifa.Stop_Err), 32'h0);
    check_eq("latch_errcnt", 32'(ifa.Err_Cnt), 32'h2);

    // A: mark parity satisfied by 1, space parity violated by 1
    cfg_pe = 1'b1; cfg_pm = 2'b10;
    send_frame(8, 9'h012, 1, 1'b1, 1'b1, 0, 1'b1);
    check_eq("mark_perr", 32'(ifa.Parity_Err), 32'h0);
    cfg_pm = 2'b11;
    send_frame(8, 9'h012, 1, 1'b1, 1'b1, 0, 1'b1);
    check_eq("space_perr",   32'(ifa.Parity_Err), 32'h1);
    check_eq("space_errcnt", 32'(ifa.Err_Cnt), 32'h3);

    // A: break - all zeros incl. parity (even of 0 = 0) and STOP1
    cfg_pm = 2'b00;
    send_frame(8, 9'h000, 1, 1'b0, 1'b0, 0, 1'b1);
    check_eq("brk_det",    32'(ifa.Break_Det), 32'h1);
    check_eq("brk_serr",   32'(ifa.Stop_Err), 32'h1);
    check_eq("brk_perr",   32'(ifa.Parity_Err), 32'h0);
    check_eq("brk_errcnt", 32'(ifa.Err_Cnt), 32'h4);
    @(negedge clk);

    // A: abort after 4 data bits (coincident with a 0 strobe), then 0x3C
    cnt_snap = dv_cnt_a;
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    abort = 1'b1; bav = 1'b1; sbit = 1'b0;
    @(negedge clk);
    abort = 1'b0; bav = 1'b0; sbit = 1'b1;
    @(negedge clk);
    check_eq("abort_hold_serr", 32'(ifa.Stop_Err), 32'h1);
    check_eq("abort_hold_brk",  32'(ifa.Break_Det), 32'h1);
    send_frame(8, 9'h03C, 1, 1'b0, 1'b1, 0, 1'b1);
    check_eq("post_abort_pdata",  32'(ifa.P_Data), 32'h3C);
    check_eq("post_abort_perr",   32'(ifa.Parity_Err), 32'h0);
    check_eq("post_abort_serr",   32'(ifa.Stop_Err), 32'h0);
    check_eq("post_abort_errcnt", 32'(ifa.Err_Cnt), 32'h4);
    @(negedge clk);
    check_eq("abort_dv_count", 32'(dv_cnt_a - cnt_snap), 32'd1);

    // A: reset mid-frame
    cnt_snap = dv_cnt_a;
    strobe(1'b0);
    for (int i = 0; i < 3; i++) strobe(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_pdata",  32'(ifa.P_Data), 32'h0);
    check_eq("midrst_errcnt", 32'(ifa.Err_Cnt), 32'h0);
    check_eq("midrst_serr",   32'(ifa.Stop_Err), 32'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("midrst_no_dv", 32'(dv_cnt_a - cnt_snap), 32'd0);
    send_frame(8, 9'h0A5, 1, 1'b0, 1'b1, 0, 1'b1);
    check_eq("after_rst_dv",    32'(ifa.Data_Valid), 32'h1);
    check_eq("after_rst_pdata", 32'(ifa.P_Data), 32'hA5);
    check_eq("after_rst_err",   32'(ifa.Err_Cnt), 32'h0);
    @(negedge clk);

    // B: DW=7, no parity, two stops, 0x55, stops 1 then 0
    sel = 1; cfg_pe = 1'b0; cfg_pm = 2'b00; cfg_s2 = 1'b1;
    strobe(1'b0);
    for (int i = 0; i < 7; i++) strobe((7'h55 >> i) & 7'h1);
    strobe(1'b1);
    check_eq("b_no_dv_after_stop1", 32'(ifb.Data_Valid), 32'h0);
    strobe(1'b0);
    check_eq("b_dv",     32'(ifb.Data_Valid), 32'h1);
    check_eq("b_pdata",  32'(ifb.P_Data), 32'h55);
    check_eq("b_serr",   32'(ifb.Stop_Err), 32'h1);
    check_eq("b_perr",   32'(ifb.Parity_Err), 32'h0);
    check_eq("b_brk",    32'(ifb.Break_Det), 32'h0);
    check_eq("b_errcnt", 32'(ifb.Err_Cnt), 32'h1);
    @(negedge clk);

    // C: CW=2, four errored frames saturate at 3
    sel = 2; cfg_pe = 1'b0; cfg_s2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send_frame(8, 9'h000, 0, 1'b0, 1'b0, 0, 1'b1);
      check_eq($sformatf("c_errcnt_%0d", k), 32'(ifc.Err_Cnt), (k > 3) ? 32'd3 : 32'(k));
    end
    @(negedge clk);
    check_eq("c_dv_count", 32'(dv_cnt_c), 32'd4);
    check_eq("a_untouched_by_c", 32'(dv_cnt_a - cnt_snap), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
